// File: rtl/gray_uart_tx_pkg.sv
// Shared FSM state type and default constants for the gray-pixel UART transmitter.
package gray_uart_tx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned FIFO_DEPTH_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/gray_tx_fifo.sv
// Single-clock byte FIFO with an explicit occupancy count and registered ready/empty flags.
module gray_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] head_c,
    output logic       ready,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    // Acceptance uses the registered flags, so a write offered while full is refused even if a pop happens.
    assign push   = wr_en && ready;
    assign pop    = rd_en && !empty;
    assign head_c = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            ready <= (count_nxt != CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gray_uart_tx.sv
// Buffered UART transmitter for gray pixel bytes (8N1, or 8E1 when GRAY_UART_TX_PARITY_EN is defined).
module gray_uart_tx
    import gray_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       head_c;
    logic             fifo_ready;
    logic             fifo_empty;
    logic             pop;
    logic             bit_done;
`ifdef GRAY_UART_TX_PARITY_EN
    logic             parity;
`endif

    assign pop      = (state == IDLE) && !fifo_empty;
    assign bit_done = (baud_cnt == '0);
    assign o_ready  = fifo_ready;

    gray_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .rd_en   (pop),
        .head_c  (head_c),
        .ready   (fifo_ready),
        .empty   (fifo_empty)
    );

    // o_tx is driven from the state held during the previous cycle, so the line lags the FSM by one clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
`ifdef GRAY_UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            o_busy <= (state != IDLE) || !fifo_empty;
            if (i_valid && !fifo_ready) o_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (pop) begin
                        shift    <= head_c;
                        baud_cnt <= CNT_LOAD;
                        bit_idx  <= '0;
`ifdef GRAY_UART_TX_PARITY_EN
                        parity   <= ^head_c;
`endif
                        state    <= START;
                    end
                end
                START: begin
                    o_tx <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= CNT_LOAD;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    o_tx <= shift[0];
                    if (bit_done) begin
                        baud_cnt <= CNT_LOAD;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef GRAY_UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
`ifdef GRAY_UART_TX_PARITY_EN
                PARITY: begin
                    o_tx <= parity;
                    if (bit_done) begin
                        baud_cnt <= CNT_LOAD;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    o_tx <= 1'b1;
                    if (bit_done) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_uart_tx.sv
// Randomized self-checking bench for gray_uart_tx against a frame-timing model of the serial line.
module tb_gray_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef GRAY_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    gray_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_data     (data),
        .o_ready    (ready),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Model: accepted bytes queue up; each popped byte owns FRAME_CYC line cycles starting one edge after the pop.
    initial begin : model
        logic [7:0]  q[$];
        logic [10:0] fb;
        logic [7:0]  d;
        int          p_edge;
        int          pop_ok;
        bit          have_frame;
        bit          m_tx, m_busy, m_ready, m_ovf;
        bit          pop_now, acc, in_frame;
        int          pre;
        have_frame = 0; pop_ok = 0; p_edge = 0; fb = '1;
        m_tx = 1; m_busy = 0; m_ready = 1; m_ovf = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                q.delete();
                have_frame = 0; pop_ok = 0;
                m_tx = 1; m_busy = 0; m_ready = 1; m_ovf = 0;
            end else begin
                pre      = q.size();
                in_frame = have_frame && (edge_n - 1 >= p_edge) && (edge_n - 1 <= p_edge + FRAME_CYC - 1);
                m_busy   = in_frame || (pre > 0);
                pop_now  = (pre > 0) && (edge_n >= pop_ok);
                acc      = valid && (pre < DEPTH);
                if (pop_now) begin
                    d     = q.pop_front();
                    fb    = '1;
                    fb[0] = 1'b0;
                    fb[8:1] = d;
`ifdef GRAY_UART_TX_PARITY_EN
                    fb[9] = ^d;
`endif
                    p_edge     = edge_n;
                    have_frame = 1;
                    pop_ok     = edge_n + FRAME_CYC + 1;
                end
                if (acc) q.push_back(data);
                else if (valid) m_ovf = 1;
                m_ready = (q.size() < DEPTH);
                if (have_frame && edge_n >= p_edge + 1 && edge_n <= p_edge + FRAME_CYC)
                    m_tx = fb[(edge_n - p_edge - 1) / CPB];
                else
                    m_tx = 1;
            end
            #1;
            chk("model_tx", 32'(tx), 32'(m_tx));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_ready", 32'(ready), 32'(m_ready));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Hand-written line pattern for one isolated frame, plus busy dropping one cycle after STOP.
    task automatic frame_lit(input string name, input logic [10:0] lit);
        for (int k = 1; k <= FRAME_CYC + 2; k++) begin
            @(posedge clk);
            #2;
            if (k == 1) chk({name, "_idle"}, 32'(tx), 32'd1);
            else if (k <= FRAME_CYC + 1) chk({name, "_bit"}, 32'(tx), 32'(lit[(k - 2) / CPB]));
            if (k == FRAME_CYC + 1) chk({name, "_busy_hi"}, 32'(busy), 32'd1);
            if (k == FRAME_CYC + 2) begin
                chk({name, "_busy_lo"}, 32'(busy), 32'd0);
                chk({name, "_tx_end"}, 32'(tx), 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [10:0] lit;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);

`ifdef GRAY_UART_TX_PARITY_EN
        lit = 11'b1_0_10100101_0;
`else
        lit = 11'b0_1_10100101_0;
`endif
        send(8'hA5);
        frame_lit("a5", lit);
        repeat (5) @(negedge clk);

`ifdef GRAY_UART_TX_PARITY_EN
        lit = 11'b1_1_00000111_0;
`else
        lit = 11'b0_1_00000111_0;
`endif
        send(8'h07);
        frame_lit("x07", lit);
        repeat (5) @(negedge clk);

        // All-zero then all-one data fields back to back.
        @(negedge clk); valid = 1'b1; data = 8'h00;
        @(negedge clk); data = 8'hFF;
        @(negedge clk); valid = 1'b0;
        repeat (2 * FRAME_CYC + 20) @(negedge clk);

        // Fill to capacity (one byte leaves the FIFO early), then offer 0x55 while full.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            valid = 1'b1;
            data  = 8'(i);
        end
        @(negedge clk);
        chk("full_ready_lo", 32'(ready), 32'd0);
        chk("full_no_ovf_yet", 32'(overflow), 32'd0);
        data = 8'h55;
        @(negedge clk);
        valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (17 * (FRAME_CYC + 1) + 20) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("drained_busy", 32'(busy), 32'd0);

        // Reset during DATA abandons the frame immediately.
        send(8'h3C);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_data_bit", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME_CYC + 20) @(negedge clk);
        chk("post_rst_quiet_tx", 32'(tx), 32'd1);
        chk("post_rst_quiet_busy", 32'(busy), 32'd0);

        // Sparse random traffic.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 44) == 0);
            data  = 8'($urandom);
        end
        // Dense random bursts that overrun the buffer.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (18 * (FRAME_CYC + 1) + 20) @(negedge clk);

        do_reset();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
